uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of the UART receiver. Captures each
//  rx_data byte qualified by the one-cycle rx_valid pulse into a circular FIFO.

---
 rtl/uart_rx_fifo_if.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the receive-side signals of uart_rx_fifo:
//   - receiver write strobe (rx_data / rx_valid)
//   - consumer first-word-fall-through read port (rd_data / rd_valid / rd_ready)
//   - status and overflow reporting (count, full, overrun, overrun_clr, drop_count)
// Modports:
//   slave  : the FIFO itself (drives read data and status)
//   master : whatever surrounds the FIFO (receiver + consumer + status reader)
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  overrun;
  logic                  overrun_clr;
  logic [7:0]            drop_count;

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rd_ready,
    input  overrun_clr,
    output rd_data,
    output rd_valid,
    output count,
    output full,
    output overrun,
    output drop_count
  );

  modport master (
    output rx_data,
    output rx_valid,
    output rd_ready,
    output overrun_clr,
    input  rd_data,
    input  rd_valid,
    input  count,
    input  full,
    input  overrun,
    input  drop_count
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer sitting directly behind a UART receiver. Every byte offered
// with the single-cycle rx_valid strobe is written into a circular FIFO and
// presented to the consumer on a first-word-fall-through valid/ready port.
// The receiver cannot be back-pressured, so bytes that arrive while the FIFO
// is full (and nothing is popped that cycle) are dropped and accounted for.
//
// Ports:
//   clock  : system clock, everything on the rising edge
//   reset  : asynchronous, active-low reset
//   bus    : uart_rx_fifo_if.slave
//            rx_data/rx_valid          write side from the receiver
//            rd_data/rd_valid/rd_ready FWFT read side to the consumer
//            count/full                fill level (0..DEPTH) and full flag
//            overrun/drop_count        sticky loss flag, saturating loss count
//            overrun_clr               clears overrun and drop_count
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic           clock,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
  localparam logic [7:0]    DROP_MAX  = 8'hFF;

  // Storage is deliberately not reset; only pointers and flags are.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          rd_valid_q;
  logic          full_q;
  logic          overrun_q;
  logic [7:0]    drop_q;

  logic pop;
  logic push;
  logic drop;

  // A pop while full frees the slot the incoming byte needs, so the write
  // is still accepted in that case. rd_ready on an empty FIFO is ignored,
  // and since rd_valid is registered a byte arriving into an empty FIFO
  // can never be popped in the same cycle.
  always_comb begin
    pop     = rd_valid_q & bus.rd_ready;
    push    = bus.rx_valid & (~full_q | pop);
    drop    = bus.rx_valid & full_q & ~pop;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, fill count and the registered valid/full flags. The flags are
  // computed from the next count so they line up with count every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q    <= count_d;
      rd_valid_q <= (count_d != '0);
      full_q     <= (count_d == COUNT_MAX);
    end
  end

  // Storage write. When full and popping, wr_ptr equals rd_ptr; the old head
  // is consumed this cycle, so overwriting it at the edge is safe.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  // Overflow bookkeeping. A drop in the same cycle as a clear wins, leaving
  // overrun set and exactly one byte counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (drop) begin
        overrun_q <= 1'b1;
        if (bus.overrun_clr) begin
          drop_q <= 8'd1;
        end else if (drop_q != DROP_MAX) begin
          drop_q <= drop_q + 8'd1;
        end
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
        drop_q    <= '0;
      end
    end
  end

  // First-word-fall-through: the head entry is always visible on rd_data.
  assign bus.rd_data    = mem[rd_ptr];
  assign bus.rd_valid   = rd_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.overrun    = overrun_q;
  assign bus.drop_count = drop_q;

  // Structural invariants of the circular buffer.
  a_count_bound : assert property (@(posedge clock) disable iff (!reset)
    count_q <= COUNT_MAX);

  a_valid_matches_count : assert property (@(posedge clock) disable iff (!reset)
    rd_valid_q == (count_q != '0));

  a_full_matches_count : assert property (@(posedge clock) disable iff (!reset)
    full_q == (count_q == COUNT_MAX));

  a_ptr_distance : assert property (@(posedge clock) disable iff (!reset)
    (wr_ptr - rd_ptr) == count_q[AW-1:0]);

  a_head_stable : assert property (@(posedge clock) disable iff (!reset)
    (rd_valid_q && !bus.rd_ready) |=> $stable(bus.rd_data));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. A queue-based reference model tracks
// the stored bytes and overflow state; every cycle the DUT outputs are
// compared with it. A small vector table covers latency/ordering, and
// hand-written sequences cover fill/overflow, full+pop, wrap, saturation,
// clear priority and asynchronous reset, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;

  logic clock;
  logic reset;

  uart_rx_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, plus overflow state.
  logic [7:0] mq [$];
  bit         mOvr;
  int         mDrop;

  typedef struct packed {
    logic       rxv;
    logic [7:0] rxd;
    logic       rdy;
    logic       clr;
    logic [4:0] eCount;
    logic       eValid;
    logic [7:0] eData;
    logic       eFull;
    logic       eOvr;
    logic [7:0] eDrop;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural rule: pop first if anything is stored, then accept the byte
  // if there is room, otherwise count it as lost. Clear happens before the
  // loss so a same-cycle loss survives it.
  task automatic modelStep(input logic v, input logic [7:0] d, input logic r, input logic c);
    if (c) begin
      mOvr  = 1'b0;
      mDrop = 0;
    end
    if (r && mq.size() > 0) begin
      void'(mq.pop_front());
    end
    if (v) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(d);
      end else begin
        mOvr = 1'b1;
        if (mDrop < 255) mDrop++;
      end
    end
  endtask

  task automatic checkOutput();
    chk("rd_valid", int'(bus.rd_valid), int'(mq.size() != 0));
    chk("count", int'(bus.count), mq.size());
    chk("full", int'(bus.full), int'(mq.size() == DEPTH));
    chk("overrun", int'(bus.overrun), int'(mOvr));
    chk("drop_count", int'(bus.drop_count), mDrop);
    if (mq.size() != 0) begin
      chk("rd_data", int'(bus.rd_data), int'(mq[0]));
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge happen,
  // update the model, then compare at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic c);
    bus.rx_valid    = v;
    bus.rx_data     = d;
    bus.rd_ready    = r;
    bus.overrun_clr = c;
    @(posedge clock);
    modelStep(v, d, r, c);
    @(negedge clock);
    bus.rx_valid    = 1'b0;
    bus.rd_ready    = 1'b0;
    bus.overrun_clr = 1'b0;
    checkOutput();
  endtask

  task automatic doReset();
    reset           = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = '0;
    bus.rd_ready    = 1'b0;
    bus.overrun_clr = 1'b0;
    mq.delete();
    mOvr  = 1'b0;
    mDrop = 0;
    repeat (2) @(negedge clock);
    checkOutput();
    reset = 1'b1;
    @(negedge clock);
    checkOutput();
  endtask

  task automatic fillFifo(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, base + 8'(i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0;

    // Latency and ordering vectors, expected values worked out by hand.
    //            rxv   rxd    rdy   clr   cnt   vld   data   full  ovr   drop
    vecs[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 1'b1, 8'h55, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 8'hA3, 1'b0, 1'b0, 5'd2, 1'b1, 8'h55, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{1'b1, 8'h0F, 1'b0, 1'b0, 5'd3, 1'b1, 8'h55, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd3, 1'b1, 8'h55, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b1, 8'hA3, 1'b0, 1'b0, 8'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 8'h0F, 1'b0, 1'b0, 8'd0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[8] = '{1'b1, 8'h3C, 1'b1, 1'b0, 5'd1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'd0};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};

    doReset();
    $display("[TB] latency/order vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rxv, vecs[i].rxd, vecs[i].rdy, vecs[i].clr);
      chk("vec_count", int'(bus.count), int'(vecs[i].eCount));
      chk("vec_valid", int'(bus.rd_valid), int'(vecs[i].eValid));
      chk("vec_full", int'(bus.full), int'(vecs[i].eFull));
      chk("vec_overrun", int'(bus.overrun), int'(vecs[i].eOvr));
      chk("vec_drop", int'(bus.drop_count), int'(vecs[i].eDrop));
      if (vecs[i].eValid) chk("vec_data", int'(bus.rd_data), int'(vecs[i].eData));
    end

    // Fill and overflow: two bytes beyond capacity are lost.
    $display("[TB] fill/overflow");
    doReset();
    fillFifo(8'h00);
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    chk("ovf_full", int'(bus.full), 1);
    chk("ovf_count", int'(bus.count), 16);
    chk("ovf_overrun", int'(bus.overrun), 1);
    chk("ovf_drop", int'(bus.drop_count), 2);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", int'(bus.rd_data), i);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", int'(bus.rd_valid), 0);

    // Full with simultaneous pop and push: the write is accepted.
    $display("[TB] full plus pop");
    doReset();
    fillFifo(8'h20);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    chk("fp_count", int'(bus.count), 16);
    chk("fp_overrun", int'(bus.overrun), 0);
    chk("fp_head", int'(bus.rd_data), 8'h21);
    for (int i = 0; i < DEPTH - 1; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("fp_tail", int'(bus.rd_data), 8'h77);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around: 40 bytes through the buffer, consumer toggling.
    $display("[TB] wrap-around");
    doReset();
    begin
      int sent = 0;
      int cyc  = 0;
      while (sent < 40) begin
        logic v;
        v = (cyc % 3) != 0;
        applyStimulus(v, 8'(8'hC0 + sent), 1'(cyc % 2), 1'b0);
        if (v) sent++;
        cyc++;
      end
      while (mq.size() != 0 && cyc < 200) begin
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        cyc++;
      end
    end
    chk("wrap_nodrop", int'(bus.drop_count), 0);
    chk("wrap_noovr", int'(bus.overrun), 0);
    chk("wrap_empty", int'(bus.rd_valid), 0);

    // Saturation, clear racing a drop, then a plain clear.
    $display("[TB] saturation/clear");
    doReset();
    fillFifo(8'h40);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    end
    chk("sat_drop", int'(bus.drop_count), 255);
    chk("sat_overrun", int'(bus.overrun), 1);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clrdrop_overrun", int'(bus.overrun), 1);
    chk("clrdrop_drop", int'(bus.drop_count), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_overrun", int'(bus.overrun), 0);
    chk("clr_drop", int'(bus.drop_count), 0);
    chk("clr_keeps_data", int'(bus.count), 16);

    // Asynchronous reset in the middle of traffic, checked before any edge.
    $display("[TB] async reset");
    doReset();
    fillFifo(8'h60);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_valid", int'(bus.rd_valid), 0);
    chk("arst_full", int'(bus.full), 0);
    chk("arst_overrun", int'(bus.overrun), 0);
    chk("arst_drop", int'(bus.drop_count), 0);
    mq.delete();
    mOvr  = 1'b0;
    mDrop = 0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput();
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("arst_after", int'(bus.rd_data), 8'h5A);

    // Random traffic against the model.
    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'(($urandom % 10) < 6), 8'($urandom), 1'($urandom % 2),
                    1'(($urandom % 40) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
